// File: rtl/alu_arbiter_if.sv
// Requester, ALU and status signals of alu_arbiter grouped into one bundle.
// slave = arbiter side, master = requesters/ALU/environment side.
interface alu_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ*3-1:0]          req_op_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [RESULT_WIDTH-1:0]       rsp_result_o;
  logic                          err_timeout_o;
  logic                          alu_valid_o;
  logic                          alu_ready_i;
  logic [2:0]                    alu_op_o;
  logic [DATA_WIDTH-1:0]         alu_a_o;
  logic [DATA_WIDTH-1:0]         alu_b_o;
  logic                          alu_done_i;
  logic [RESULT_WIDTH-1:0]       alu_result_i;
  logic                          busy_o;
  logic [IDW-1:0]                grant_id_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i,
    input  alu_ready_i, alu_done_i, alu_result_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, err_timeout_o,
    output alu_valid_o, alu_op_o, alu_a_o, alu_b_o, busy_o, grant_id_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i,
    output alu_ready_i, alu_done_i, alu_result_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, err_timeout_o,
    input  alu_valid_o, alu_op_o, alu_a_o, alu_b_o, busy_o, grant_id_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU among NUM_REQ requesters.
// Define ALU_ARB_TIMEOUT_EN to add a WAIT-state watchdog that aborts after TIMEOUT cycles.
//
// state    | meaning
// ST_IDLE  | no operation owned; round-robin grant when any request is valid
// ST_ISSUE | alu_valid_o held with captured operation until alu_ready_i
// ST_WAIT  | waiting for alu_done_i (or timeout when enabled)
// ST_RESP  | one-cycle rsp_valid_o pulse to the owner, last_grant updated
module alu_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("alu_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("alu_arbiter: TIMEOUT must be 1..65535");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t                  state;
  logic [IDW-1:0]          last_grant;
  logic [IDW-1:0]          grant;
  logic [2:0]              op_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [RESULT_WIDTH-1:0] result_q;
  logic                    alu_valid_q;
  logic                    busy_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;

  logic                    sel_found;
  logic [IDW-1:0]          sel_idx;
  logic [2:0]              sel_op;
  logic [DATA_WIDTH-1:0]   sel_a;
  logic [DATA_WIDTH-1:0]   sel_b;
  logic [NUM_REQ-1:0]      ready_c;

`ifdef ALU_ARB_TIMEOUT_EN
  logic [15:0]             tmo_cnt;
  logic                    err_q;
`endif

  // Search starts one past the previous owner so every requester is reached within NUM_REQ grants.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_found && bus.req_valid_i[(int'(last_grant) + k) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    sel_op = bus.req_op_i[3*int'(sel_idx) +: 3];
    sel_a  = bus.req_a_i[DATA_WIDTH*int'(sel_idx) +: DATA_WIDTH];
    sel_b  = bus.req_b_i[DATA_WIDTH*int'(sel_idx) +: DATA_WIDTH];
  end

  // Accept strobe is combinational so the requester sees it in the grant cycle; forced low in reset.
  always_comb begin
    ready_c = '0;
    if (rst_i && state == ST_IDLE && sel_found) ready_c[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      last_grant  <= IDW'(NUM_REQ - 1);
      grant       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      alu_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            grant       <= sel_idx;
            op_q        <= sel_op;
            a_q         <= sel_a;
            b_q         <= sel_b;
            alu_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.alu_ready_i) begin
            alu_valid_q <= 1'b0;
            state       <= ST_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (bus.alu_done_i) begin
            result_q    <= bus.alu_result_i;
            rsp_valid_q <= NUM_REQ'(1) << grant;
            state       <= ST_RESP;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          // Done is checked first, so a done arriving on the final cycle is not flagged as a timeout.
          else if (tmo_cnt + 16'd1 == 16'(TIMEOUT)) begin
            result_q    <= '0;
            rsp_valid_q <= NUM_REQ'(1) << grant;
            err_q       <= 1'b1;
            state       <= ST_RESP;
          end else begin
            tmo_cnt     <= tmo_cnt + 16'd1;
          end
`endif
        end
        ST_RESP: begin
          last_grant <= grant;
          busy_q     <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = ready_c;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_result_o = result_q;
  assign bus.alu_valid_o  = alu_valid_q;
  assign bus.alu_op_o     = op_q;
  assign bus.alu_a_o      = a_q;
  assign bus.alu_b_o      = b_q;
  assign bus.busy_o       = busy_q;
  assign bus.grant_id_o   = grant;
`ifdef ALU_ARB_TIMEOUT_EN
  assign bus.err_timeout_o = err_q;
`else
  assign bus.err_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected grants, ALU issues and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_alu_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int RW = 16;

  typedef struct {
    int         idx;
    logic [15:0] res;
    logic       err;
  } exp_rsp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } exp_iss_t;

  logic clk_i;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;

  int       exp_grant[$];
  exp_iss_t exp_iss[$];
  exp_rsp_t exp_rsp[$];

  int       mon_g;
  exp_iss_t mon_s;
  exp_rsp_t mon_r;

  alu_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .RESULT_WIDTH(RW)) bus ();

  alu_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .TIMEOUT(10)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_result_o, bus.err_timeout_o,
               bus.alu_valid_o, bus.alu_op_o, bus.alu_a_o, bus.alu_b_o, bus.busy_o,
               bus.grant_id_o}, 64'd0);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_op_i[3*i +: 3]  = op;
    bus.req_a_i[8*i +: 8]   = a;
    bus.req_b_i[8*i +: 8]   = b;
  endtask

  task automatic expect_op(input int g, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_iss_t s;
    exp_grant.push_back(g);
    s.op = op; s.a = a; s.b = b;
    exp_iss.push_back(s);
  endtask

  task automatic expect_rsp(input int g, input logic [15:0] res, input logic err);
    exp_rsp_t r;
    r.idx = g; r.res = res; r.err = err;
    exp_rsp.push_back(r);
  endtask

  // Stub ALU behaviour used to produce alu_result_i.
  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return 16'(a) - 16'(b);
      3'd3:    return {a, b};
      default: return 16'(a ^ b);
    endcase
  endfunction

  // Plays the ALU for one operation: optional backpressure (with an optional stray done in ISSUE),
  // then done after `delay` WAIT cycles unless never_done.
  task automatic serve_alu(input int stall, input int delay, input bit never_done, input bit stray);
    int n;
    logic [2:0] op0;
    logic [7:0] a0, b0;
    n = 0;
    while (!bus.alu_valid_o && n < 50) begin
      tick();
      n++;
    end
    if (!bus.alu_valid_o) begin
      chk("alu_valid_wait_expired", 64'(bus.alu_valid_o), 64'd1);
      return;
    end
    op0 = bus.alu_op_o; a0 = bus.alu_a_o; b0 = bus.alu_b_o;
    for (int k = 0; k < stall; k++) begin
      if (stray && k == 0) begin
        bus.alu_done_i   = 1'b1;
        bus.alu_result_i = 16'hBEEF;
      end
      tick();
      bus.alu_done_i   = 1'b0;
      bus.alu_result_i = '0;
      chk("hold_alu_valid", 64'(bus.alu_valid_o), 64'd1);
      chk("hold_operands", {bus.alu_op_o, bus.alu_a_o, bus.alu_b_o}, {op0, a0, b0});
    end
    bus.alu_ready_i = 1'b1;
    tick();
    bus.alu_ready_i = 1'b0;
    if (never_done) return;
    repeat (delay - 1) tick();
    bus.alu_done_i   = 1'b1;
    bus.alu_result_i = alu_f(op0, a0, b0);
    tick();
    bus.alu_done_i   = 1'b0;
    bus.alu_result_i = '0;
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (bus.req_ready_o != '0) begin
        chk("ready_onehot", 64'($onehot(bus.req_ready_o)), 64'd1);
        if (exp_grant.size() == 0) chk("unexpected_grant", 64'(bus.req_ready_o), 64'd0);
        else begin
          mon_g = exp_grant.pop_front();
          chk("grant", 64'(bus.req_ready_o), 64'(1) << mon_g);
        end
      end
      if (bus.alu_valid_o && bus.alu_ready_i) begin
        if (exp_iss.size() == 0) chk("unexpected_issue", 64'd1, 64'd0);
        else begin
          mon_s = exp_iss.pop_front();
          chk("issue_ops", {bus.alu_op_o, bus.alu_a_o, bus.alu_b_o}, {mon_s.op, mon_s.a, mon_s.b});
        end
      end
      if (bus.rsp_valid_o != '0) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 64'(bus.rsp_valid_o), 64'd0);
        else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(1) << mon_r.idx);
          chk("rsp_result", 64'(bus.rsp_result_o), 64'(mon_r.res));
          chk("rsp_err", 64'(bus.err_timeout_o), 64'(mon_r.err));
          chk("rsp_grant_id", 64'(bus.grant_id_o), 64'(mon_r.idx));
        end
      end
    end
  end

  initial begin
    rst_i = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_op_i     = '0;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.alu_ready_i  = 1'b0;
    bus.alu_done_i   = 1'b0;
    bus.alu_result_i = '0;
    tick(); tick();
    chk_outputs_zero("reset_outputs");
    rst_i = 1'b1;
    tick();

    // Single request from requester 2: 0x12 + 0x34
    set_req(2, 3'd1, 8'h12, 8'h34);
    expect_op(2, 3'd1, 8'h12, 8'h34);
    expect_rsp(2, 16'h0046, 1'b0);
    bus.req_valid_i = 4'b0100;
    serve_alu(0, 3, 0, 0);
    bus.req_valid_i = '0;
    repeat (3) tick();

    // Fairness after a fresh reset: all four valid, order 0,1,2,3,0
    rst_i = 1'b0;
    tick(); tick();
    chk_outputs_zero("reset2_outputs");
    rst_i = 1'b1;
    set_req(0, 3'd1, 8'h10, 8'h00);
    set_req(1, 3'd1, 8'h20, 8'h01);
    set_req(2, 3'd1, 8'h30, 8'h02);
    set_req(3, 3'd1, 8'h40, 8'h03);
    expect_op(0, 3'd1, 8'h10, 8'h00); expect_rsp(0, 16'h0010, 1'b0);
    expect_op(1, 3'd1, 8'h20, 8'h01); expect_rsp(1, 16'h0021, 1'b0);
    expect_op(2, 3'd1, 8'h30, 8'h02); expect_rsp(2, 16'h0032, 1'b0);
    expect_op(3, 3'd1, 8'h40, 8'h03); expect_rsp(3, 16'h0043, 1'b0);
    expect_op(0, 3'd1, 8'h10, 8'h00); expect_rsp(0, 16'h0010, 1'b0);
    bus.req_valid_i = 4'b1111;
    for (int n = 0; n < 5; n++) serve_alu(0, 1, 0, 0);
    bus.req_valid_i = '0;
    repeat (3) tick();

    // Backpressure: 5 stalled ISSUE cycles, requester 3, concat op
    set_req(3, 3'd3, 8'hAB, 8'hCD);
    expect_op(3, 3'd3, 8'hAB, 8'hCD);
    expect_rsp(3, 16'hABCD, 1'b0);
    bus.req_valid_i = 4'b1000;
    serve_alu(5, 1, 0, 0);
    bus.req_valid_i = '0;
    repeat (3) tick();

    // Stray done in IDLE, then in ISSUE (requester 1, 0x50 - 0x20)
    bus.alu_done_i   = 1'b1;
    bus.alu_result_i = 16'hDEAD;
    tick();
    bus.alu_done_i   = 1'b0;
    bus.alu_result_i = '0;
    chk("stray_idle_busy", 64'(bus.busy_o), 64'd0);
    chk("stray_idle_rsp", 64'(bus.rsp_valid_o), 64'd0);
    tick();
    chk("stray_idle_rsp_later", 64'(bus.rsp_valid_o), 64'd0);
    set_req(1, 3'd2, 8'h50, 8'h20);
    expect_op(1, 3'd2, 8'h50, 8'h20);
    expect_rsp(1, 16'h0030, 1'b0);
    bus.req_valid_i = 4'b0010;
    serve_alu(3, 2, 0, 1);
    bus.req_valid_i = '0;
    repeat (3) tick();

    // Reset mid-WAIT on requester 2's operation; next grant must restart at requester 0
    set_req(2, 3'd1, 8'h01, 8'h02);
    expect_op(2, 3'd1, 8'h01, 8'h02);
    bus.req_valid_i = 4'b0100;
    serve_alu(0, 1, 1, 0);
    bus.req_valid_i = '0;
    tick(); tick();
    chk("mid_wait_busy", 64'(bus.busy_o), 64'd1);
    set_req(0, 3'd2, 8'h09, 8'h03);
    bus.req_valid_i = 4'b1111;
    rst_i = 1'b0;
    #1;
    chk_outputs_zero("reset_mid_wait_outputs");
    tick(); tick();
    chk_outputs_zero("reset_mid_wait_held");
    expect_op(0, 3'd2, 8'h09, 8'h03);
    expect_rsp(0, 16'h0006, 1'b0);
    rst_i = 1'b1;
    serve_alu(0, 1, 0, 0);
    bus.req_valid_i = '0;
    repeat (3) tick();

`ifdef ALU_ARB_TIMEOUT_EN
    // Timeout after 10 WAIT cycles, then done on the 10th cycle wins
    set_req(1, 3'd1, 8'h05, 8'h06);
    expect_op(1, 3'd1, 8'h05, 8'h06);
    expect_rsp(1, 16'h0000, 1'b1);
    bus.req_valid_i = 4'b0010;
    serve_alu(0, 1, 1, 0);
    bus.req_valid_i = '0;
    repeat (14) tick();
    set_req(1, 3'd1, 8'h07, 8'h08);
    expect_op(1, 3'd1, 8'h07, 8'h08);
    expect_rsp(1, 16'h000F, 1'b0);
    bus.req_valid_i = 4'b0010;
    serve_alu(0, 10, 0, 0);
    bus.req_valid_i = '0;
    repeat (3) tick();
`endif

    repeat (5) tick();
    chk("pending_grants", 64'(exp_grant.size()), 64'd0);
    chk("pending_issues", 64'(exp_iss.size()), 64'd0);
    chk("pending_rsps", 64'(exp_rsp.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one ALU (2..8).
REQ-002 Parameter DATA_WIDTH, default 8: operand width.
REQ-003 Parameter RESULT_WIDTH, default 16: ALU result width.
REQ-004 Parameter TIMEOUT, default 255: maximum WAIT cycles before abort (1..65535).
REQ-005 clk_i  input  1  clock; all logic is rising-edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  input  NUM_REQ  per-requester operation request.
REQ-008 req_ready_o  output  NUM_REQ  per-requester accept strobe, at most one bit high per cycle.
REQ-009 req_op_i  input  NUM_REQ*3  per-requester opcode; slice i is bits [3i+2:3i].
REQ-010 req_a_i, req_b_i  input  NUM_REQ*DATA_WIDTH each  per-requester operands, sliced as for req_op_i.
REQ-011 rsp_valid_o  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-012 rsp_result_o  output  RESULT_WIDTH  result; valid only while any rsp_valid_o bit is high.
REQ-013 err_timeout_o  output  1  high with rsp_valid_o when the completion was a timeout abort.
REQ-014 alu_valid_o  output  1  operation start request to the ALU.
REQ-015 alu_ready_i  input  1  ALU accepts the operation when high with alu_valid_o.
REQ-016 alu_op_o, alu_a_o, alu_b_o  output  3/DATA_WIDTH/DATA_WIDTH  registered operation to the ALU.
REQ-017 alu_done_i, alu_result_i  input  1/RESULT_WIDTH  ALU completion and result.
REQ-018 busy_o  output  1  high in every state except IDLE.
REQ-019 grant_id_o  output  $clog2(NUM_REQ)  index of the current or most recent grant.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-021 In IDLE with any req_valid_i bit set, the block SHALL select requester g by round-robin, searching from last_grant+1 upward modulo NUM_REQ.
REQ-022 In that same cycle, req_ready_o[g] SHALL be high, op/a/b of slice g SHALL be captured, and the FSM SHALL go to ISSUE.
REQ-023 In ISSUE, alu_valid_o SHALL be high with the captured operation, held stable until alu_ready_i is sampled high, then the FSM SHALL go to WAIT.
REQ-024 In WAIT, when alu_done_i is high, alu_result_i SHALL be captured and the FSM SHALL go to RESP.
REQ-025 alu_done_i SHALL be ignored in IDLE, ISSUE and RESP.
REQ-026 In RESP, rsp_valid_o[g] SHALL be high for exactly one cycle with the captured result, last_grant SHALL be set to g, and the FSM SHALL return to IDLE.
REQ-027 Minimum service time SHALL be 4 cycles per operation (accept, issue, done, respond).
REQ-028 The next grant SHALL be decided no earlier than the IDLE cycle after RESP.
REQ-029 A requester withdrawing req_valid_i before its grant SHALL lose no state and SHALL not be granted.
REQ-030 A grant is never revoked once issued.
REQ-031 Opcodes SHALL pass through to the ALU unmodified; the block does no arithmetic.

Reset
REQ-032 While rst_i is low, the FSM SHALL be IDLE and last_grant SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-033 While rst_i is low, all outputs SHALL be 0, including captured registers and the timeout counter.
REQ-034 Reset asserted mid-operation SHALL abort it without any rsp_valid_o pulse.
REQ-035 After release, alu_done_i SHALL be ignored until a new ISSUE handshake.

Configuration
REQ-036 With ALU_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-037 With ALU_ARB_TIMEOUT_EN defined, if the counter reaches TIMEOUT without alu_done_i, the FSM SHALL go to RESP with result 0 and err_timeout_o high.
REQ-038 With ALU_ARB_TIMEOUT_EN defined, if alu_done_i and timeout coincide, done SHALL win and err_timeout_o SHALL stay 0.
REQ-039 Without ALU_ARB_TIMEOUT_EN, no counter SHALL exist, err_timeout_o SHALL be tied 0, and WAIT SHALL wait indefinitely.

Verification
REQ-040 Single request: req 2 valid, op=1, a=0x12, b=0x34; ALU ready at once, done after 3 cycles with 0x0046 -> req_ready_o=4'b0100, one alu_valid_o, rsp_valid_o=4'b0100 with result 0x0046.
REQ-041 Fairness: all 4 valid continuously after reset -> grant order 0,1,2,3,0, one rsp pulse each, never two ready bits high.
REQ-042 Backpressure: alu_ready_i low for 5 cycles in ISSUE -> alu_valid_o and operands stable all 5 cycles, one accept only.
REQ-043 Stray done: alu_done_i pulsed in IDLE and in ISSUE -> no state change and no rsp_valid_o.
REQ-044 Timeout (macro on, TIMEOUT=10): ALU never asserts done -> rsp_valid_o after 10 WAIT cycles with result 0 and err_timeout_o=1; done on cycle 10 gives err_timeout_o=0.
REQ-045 Reset mid-WAIT: rst_i low for 2 cycles -> all outputs 0, no rsp pulse, next grant goes to requester 0.
